// File: rtl/cpu_run_monitor_if.sv
// Signal bundle between the LegV8 CPU observation taps / trace consumer and cpu_run_monitor.
interface cpu_run_monitor_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0]     reg_data;
    logic                      mem_write;
    logic [DATA_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic [DATA_WIDTH-1:0]     pc;
    logic                      trace_pop;
    logic                      trace_valid;
    logic                      trace_kind;
    logic [DATA_WIDTH-1:0]     trace_addr;
    logic [DATA_WIDTH-1:0]     trace_data;
    logic [31:0]               trace_cycle;
    logic                      trace_overflow;
    logic [31:0]               cycle_count;
    logic [1:0]                state;
    logic                      done;

    modport master (
        output reg_write, reg_addr, reg_data, mem_write, mem_addr, mem_data, pc, trace_pop,
        input  trace_valid, trace_kind, trace_addr, trace_data, trace_cycle,
        input  trace_overflow, cycle_count, state, done
    );

    modport slave (
        input  reg_write, reg_addr, reg_data, mem_write, mem_addr, mem_data, pc, trace_pop,
        output trace_valid, trace_kind, trace_addr, trace_data, trace_cycle,
        output trace_overflow, cycle_count, state, done
    );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run monitor for the LegV8 64-bit CPU: traces architectural writes into a FIFO and ends the run on halt or cycle budget.
// Optional macro CPU_RUN_MONITOR_CYCLE_STAMP_EN stores a 32-bit cycle stamp per entry; otherwise trace_cycle reads 0.
module cpu_run_monitor #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TRACE_DEPTH    = 16,
    parameter int MAX_CYCLES     = 500,
    parameter int HALT_CYCLES    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cpu_run_monitor_if.slave bus
);
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STB_W = $clog2(HALT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HALTED  = 2'b01,
        ST_TIMEOUT = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           cycle_count_q, cycle_count_d;
    logic [DATA_WIDTH-1:0] pc_prev_q, pc_prev_d;
    logic                  pc_prev_valid_q, pc_prev_valid_d;
    logic [STB_W-1:0]      stable_q, stable_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  head_kind_q, head_kind_d;
    logic [DATA_WIDTH-1:0] head_addr_q, head_addr_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;

    logic                  kind_mem_q [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0] addr_mem_q [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [TRACE_DEPTH];
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
    logic [31:0]           stamp_mem_q [TRACE_DEPTH];
    logic [31:0]           head_stamp_q, head_stamp_d;
`endif

    logic                  run_s, reg_ev_s, mem_ev_s, collide_s;
    logic                  push_req_s, push_acc_s, pop_s, full_s, drop_s;
    logic                  pc_match_s, halt_fire_s, timeout_fire_s;
    logic [STB_W-1:0]      stable_inc_s;
    logic                  ent_kind_s;
    logic [DATA_WIDTH-1:0] ent_addr_s, ent_data_s;

    // Event decode and FIFO handshake; a memory write wins the single push slot
    always_comb begin
        run_s      = (state_q == ST_RUN);
        reg_ev_s   = run_s && bus.reg_write && (bus.reg_addr != REG_ADDR_WIDTH'(31));
        mem_ev_s   = run_s && bus.mem_write;
        collide_s  = reg_ev_s && mem_ev_s;
        push_req_s = reg_ev_s || mem_ev_s;
        full_s     = (count_q == CNT_W'(TRACE_DEPTH));
        pop_s      = bus.trace_pop && (count_q != '0);
        push_acc_s = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && !push_acc_s;
        if (mem_ev_s) begin
            ent_kind_s = 1'b1;
            ent_addr_s = bus.mem_addr;
            ent_data_s = bus.mem_data;
        end else begin
            ent_kind_s = 1'b0;
            ent_addr_s = DATA_WIDTH'(bus.reg_addr);
            ent_data_s = bus.reg_data;
        end
    end

    // Halt / timeout detection
    always_comb begin
        pc_match_s     = pc_prev_valid_q && (bus.pc == pc_prev_q);
        stable_inc_s   = stable_q + STB_W'(1);
        halt_fire_s    = run_s && pc_match_s && (stable_inc_s == STB_W'(HALT_CYCLES));
        timeout_fire_s = run_s && (cycle_count_q == 32'(MAX_CYCLES - 1));
    end

    // Run-state next-state logic; halt has priority over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_fire_s) begin
                    state_d = ST_HALTED;
                end else if (timeout_fire_s) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED:  state_d = ST_HALTED;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
        done_d = (state_d != ST_RUN);
    end

    // Run counters; everything freezes once the run has ended
    always_comb begin
        cycle_count_d   = cycle_count_q;
        pc_prev_d       = pc_prev_q;
        pc_prev_valid_d = pc_prev_valid_q;
        stable_d        = stable_q;
        if (run_s) begin
            cycle_count_d   = cycle_count_q + 32'd1;
            pc_prev_d       = bus.pc;
            pc_prev_valid_d = 1'b1;
            if (pc_match_s) begin
                stable_d = stable_inc_s;
            end else begin
                stable_d = '0;
            end
        end else begin
            cycle_count_d = cycle_count_q;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d   = push_acc_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        overflow_d = overflow_q || collide_s || drop_s;
        case ({push_acc_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
    end

    // Next head entry; forward the incoming event when it lands straight at the head
    always_comb begin
        head_kind_d = 1'b0;
        head_addr_d = '0;
        head_data_d = '0;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
        head_stamp_d = 32'd0;
`endif
        if (count_d != '0) begin
            if (push_acc_s && (rd_ptr_d == wr_ptr_q)) begin
                head_kind_d = ent_kind_s;
                head_addr_d = ent_addr_s;
                head_data_d = ent_data_s;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
                head_stamp_d = cycle_count_q;
`endif
            end else begin
                head_kind_d = kind_mem_q[rd_ptr_d];
                head_addr_d = addr_mem_q[rd_ptr_d];
                head_data_d = data_mem_q[rd_ptr_d];
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
                head_stamp_d = stamp_mem_q[rd_ptr_d];
`endif
            end
        end else begin
            head_kind_d = 1'b0;
            head_addr_d = '0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_RUN;
            cycle_count_q   <= 32'd0;
            pc_prev_q       <= '0;
            pc_prev_valid_q <= 1'b0;
            stable_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            valid_q         <= 1'b0;
            done_q          <= 1'b0;
            head_kind_q     <= 1'b0;
            head_addr_q     <= '0;
            head_data_q     <= '0;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
            head_stamp_q    <= 32'd0;
`endif
        end else begin
            state_q         <= state_d;
            cycle_count_q   <= cycle_count_d;
            pc_prev_q       <= pc_prev_d;
            pc_prev_valid_q <= pc_prev_valid_d;
            stable_q        <= stable_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
            valid_q         <= valid_d;
            done_q          <= done_d;
            head_kind_q     <= head_kind_d;
            head_addr_q     <= head_addr_d;
            head_data_q     <= head_data_d;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
            head_stamp_q    <= head_stamp_d;
`endif
        end
    end

    // Trace storage; stale contents are ignored after reset through the pointers
    always_ff @(posedge clk_i) begin
        if (push_acc_s) begin
            kind_mem_q[wr_ptr_q] <= ent_kind_s;
            addr_mem_q[wr_ptr_q] <= ent_addr_s;
            data_mem_q[wr_ptr_q] <= ent_data_s;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
            stamp_mem_q[wr_ptr_q] <= cycle_count_q;
`endif
        end
    end

    assign bus.trace_valid    = valid_q;
    assign bus.trace_kind     = head_kind_q;
    assign bus.trace_addr     = head_addr_q;
    assign bus.trace_data     = head_data_q;
    assign bus.trace_overflow = overflow_q;
    assign bus.cycle_count    = cycle_count_q;
    assign bus.state          = state_q;
    assign bus.done           = done_q;
`ifdef CPU_RUN_MONITOR_CYCLE_STAMP_EN
    assign bus.trace_cycle    = head_stamp_q;
`else
    assign bus.trace_cycle    = 32'd0;
`endif
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: directed scenarios plus randomized runs against a queue-based reference model.
module tb_cpu_run_monitor;
    localparam int DW    = 64;
    localparam int RAW   = 5;
    localparam int DEPTH = 4;
    localparam int MAXC  = 24;
    localparam int HALTC = 4;

    logic clk = 1'b0;
    logic rst;

    cpu_run_monitor_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) bus ();

    cpu_run_monitor #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TRACE_DEPTH(DEPTH),
        .MAX_CYCLES(MAXC), .HALT_CYCLES(HALTC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [31:0] cyc;
    } entry_t;

    entry_t      sb_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;

    // reference model: what the monitor should be showing right now
    int          m_state;
    int          m_cnt;
    int          m_streak;
    int          m_cycle;
    logic [63:0] m_prev_pc;
    bit          m_prev_known;
    bit          m_ovf;
    int          steps_since_rst;
    logic [63:0] pc_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: status every cycle, entry contents whenever the DUT hands one over
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", 64'(bus.trace_valid), 64'(m_cnt > 0));
            chk("state", 64'(bus.state), 64'(m_state));
            chk("done", 64'(bus.done), 64'(m_state != 0));
            chk("cycle_count", 64'(bus.cycle_count), 64'(m_cycle));
            chk("overflow", 64'(bus.trace_overflow), 64'(m_ovf));
            if (bus.trace_valid && bus.trace_pop) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got addr %0h expected no entry", bus.trace_addr);
                end else begin
                    entry_t e;
                    e = sb_q.pop_front();
                    chk("head_kind", 64'(bus.trace_kind), 64'(e.kind));
                    chk("head_addr", bus.trace_addr, e.addr);
                    chk("head_data", bus.trace_data, e.data);
                    chk("head_cycle", 64'(bus.trace_cycle), 64'(e.cyc));
                end
            end else if (!bus.trace_valid) begin
                chk("empty_head", {63'd0, bus.trace_kind} | bus.trace_addr | bus.trace_data
                    | 64'(bus.trace_cycle), 64'd0);
            end
        end
    end

    // Drive one cycle of inputs, predict the outcome, advance past the edge
    task automatic step(input bit r, input bit rw, input logic [4:0] ra, input logic [63:0] rd,
                        input bit mw, input logic [63:0] ma, input logic [63:0] md,
                        input logic [63:0] pc, input bit pop);
        bit acc, pop_eff, reg_ev, n_ovf, n_known;
        int n_state, n_cnt, n_streak, n_cycle;
        logic [63:0] n_prev;
        entry_t e;
        rst           = r;
        bus.reg_write = rw;
        bus.reg_addr  = ra;
        bus.reg_data  = rd;
        bus.mem_write = mw;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.pc        = pc;
        bus.trace_pop = pop && !r;
        acc = 1'b0;
        e   = '0;
        if (r) begin
            n_state = 0; n_cnt = 0; n_streak = 0; n_cycle = 0;
            n_ovf = 1'b0; n_known = 1'b0; n_prev = 64'd0;
        end else begin
            n_state = m_state; n_cycle = m_cycle; n_ovf = m_ovf; n_streak = m_streak;
            n_known = m_prev_known; n_prev = m_prev_pc;
            pop_eff = pop && (m_cnt > 0);
            if (m_state == 0) begin
                reg_ev = rw && (ra != 5'd31);
                if (reg_ev && mw) n_ovf = 1'b1;
                e.cyc = 32'(m_cycle);
                if (mw) begin
                    e.kind = 1'b1; e.addr = ma; e.data = md;
                end else begin
                    e.kind = 1'b0; e.addr = {59'd0, ra}; e.data = rd;
                end
                if (reg_ev || mw) begin
                    if (m_cnt < DEPTH || pop_eff) acc = 1'b1;
                    else n_ovf = 1'b1;
                end
                n_streak = (m_prev_known && pc == m_prev_pc) ? m_streak + 1 : 0;
                if (n_streak == HALTC) n_state = 1;
                else if (m_cycle == MAXC - 1) n_state = 2;
                n_cycle = m_cycle + 1;
                n_prev  = pc;
                n_known = 1'b1;
            end
            n_cnt = m_cnt + int'(acc) - int'(pop_eff);
        end
`ifndef CPU_RUN_MONITOR_CYCLE_STAMP_EN
        e.cyc = 32'd0;
`endif
        @(posedge clk);
        #1;
        m_state = n_state; m_cnt = n_cnt; m_streak = n_streak; m_cycle = n_cycle;
        m_ovf = n_ovf; m_prev_known = n_known; m_prev_pc = n_prev;
        if (r) begin
            sb_q.delete();
            steps_since_rst = 0;
            pc_v = 64'd0;
        end else begin
            steps_since_rst++;
            if (acc) sb_q.push_back(e);
        end
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    endtask

    // One RUN cycle with the PC advancing by 4
    task automatic run(input bit rw, input logic [4:0] ra, input logic [63:0] rd,
                       input bit mw, input logic [63:0] ma, input logic [63:0] md, input bit pop);
        pc_v = pc_v + 64'd4;
        step(1'b0, rw, ra, rd, mw, ma, md, pc_v, pop);
    endtask

    task automatic idle(input bit pop);
        run(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, pop);
    endtask

    initial begin
        int exp_cc;
        rst = 1'b1;
        do_reset();
        do_reset();
        chk("reset_valid", 64'(bus.trace_valid), 64'd0);
        chk("reset_state", 64'(bus.state), 64'd0);

        // two register writes at cycles 2 and 3
        idle(1'b0);
        idle(1'b0);
        run(1'b1, 5'd1, 64'h5, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("t1_head_addr", bus.trace_addr, 64'd1);
        run(1'b1, 5'd2, 64'hA, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("t1_head_data", bus.trace_data, 64'h5);
        chk("t1_overflow", 64'(bus.trace_overflow), 64'd0);
        idle(1'b1);
        chk("t1_second_addr", bus.trace_addr, 64'd2);
        idle(1'b1);
        chk("t1_drained", 64'(bus.trace_valid), 64'd0);

        // XZR writes leave no trace
        do_reset();
        run(1'b1, 5'd31, 64'hFF, 1'b0, 64'd0, 64'd0, 1'b0);
        idle(1'b0);
        chk("xzr_valid", 64'(bus.trace_valid), 64'd0);
        chk("xzr_overflow", 64'(bus.trace_overflow), 64'd0);

        // six memory writes into a four-entry FIFO
        do_reset();
        for (int i = 0; i < 6; i++)
            run(1'b0, 5'd0, 64'd0, 1'b1, 64'h100 + 64'(i * 8), 64'(i + 1), 1'b0);
        chk("ovf_set", 64'(bus.trace_overflow), 64'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("ovf_drained", 64'(bus.trace_valid), 64'd0);

        // push and pop together while full
        do_reset();
        for (int i = 0; i < 4; i++)
            run(1'b0, 5'd0, 64'd0, 1'b1, 64'h200 + 64'(i * 8), 64'(i), 1'b0);
        run(1'b0, 5'd0, 64'd0, 1'b1, 64'h220, 64'h4, 1'b1);
        chk("full_pushpop_ovf", 64'(bus.trace_overflow), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // collision of register and memory write
        do_reset();
        run(1'b1, 5'd3, 64'h33, 1'b1, 64'h300, 64'h44, 1'b0);
        chk("collide_kind", 64'(bus.trace_kind), 64'd1);
        chk("collide_ovf", 64'(bus.trace_overflow), 64'd1);
        idle(1'b1);

        // halt: PC climbs to 0x20 then sticks
        do_reset();
        for (int i = 0; i < 3; i++) run(1'b1, 5'(i + 4), 64'(i), 1'b0, 64'd0, 64'd0, 1'b0);
        while (pc_v < 64'h1C) idle(1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'h20, 1'b0);
        chk("halt_not_yet", 64'(bus.state), 64'd0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'h20, 1'b0);
        chk("halt_state", 64'(bus.state), 64'd1);
        chk("halt_done", 64'(bus.done), 64'd1);
        exp_cc = steps_since_rst;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd9, 64'h9, 1'b0, 64'd0, 64'd0, 64'h20, 1'b0);
        chk("halt_frozen", 64'(bus.cycle_count), 64'(exp_cc));
        do_reset();
        chk("rst_halt_valid", 64'(bus.trace_valid), 64'd0);
        chk("rst_halt_state", 64'(bus.state), 64'd0);
        chk("rst_halt_cc", 64'(bus.cycle_count), 64'd0);

        // timeout with an ever-changing PC
        for (int i = 0; i < MAXC; i++) idle(1'b0);
        chk("timeout_state", 64'(bus.state), 64'd2);
        chk("timeout_cc", 64'(bus.cycle_count), 64'(MAXC));
        for (int i = 0; i < 3; i++) run(1'b1, 5'd7, 64'h77, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("timeout_no_capture", 64'(bus.trace_valid), 64'd0);

        // randomized runs
        for (int it = 0; it < 40; it++) begin
            int hold_pct;
            hold_pct = (it % 2 == 1) ? 60 : 15;
            do_reset();
            for (int c = 0; c < 45; c++) begin
                bit r, rw, mw, pop;
                logic [4:0] ra;
                r   = ($urandom_range(0, 99) < 2);
                rw  = ($urandom_range(0, 99) < 45);
                mw  = ($urandom_range(0, 99) < 30);
                pop = ($urandom_range(0, 99) < 35);
                ra  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                if ($urandom_range(0, 99) >= hold_pct) pc_v = pc_v + 64'd4;
                step(r, rw, ra, {32'($urandom), 32'($urandom)}, mw,
                     {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, pc_v, pop);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
